// File: rtl/accum_ctrl_pkg.sv
// Shared widths and FSM state encoding for the windowed accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package accum_ctrl_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int SUM_W_DEF  = 21;
  localparam int CNT_W_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/accum_core.sv
// Registered saturating accumulator with synchronous clear and sticky overflow.
// Latency: 1 cycle from en_i/clr_i to acc_o/ovf_o.
// Backpressure: none; the caller decides when en_i is asserted.
module accum_core
  import accum_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  acc_o,
  output logic              ovf_o
);

  // One extra bit above the wider operand holds the true sum so a carry out is visible.
  localparam int EXT_W = ((SUM_W > DATA_W) ? SUM_W : DATA_W) + 1;
  localparam logic [EXT_W-1:0] MAX_EXT = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  logic [SUM_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [EXT_W-1:0] sum_ext;

  // Next-state: clear wins over enable; an add past full scale clamps and latches overflow.
  always_comb begin
    sum_ext = EXT_W'(acc_q) + EXT_W'(data_i);
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (sum_ext > MAX_EXT) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_ext[SUM_W-1:0];
      end
    end
  end

  // Accumulator and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/accum_ctrl.sv
// Windowed accumulator: sums N accepted samples and publishes a saturated result.
// Latency: sum_valid pulses 2 cycles after the edge that accepts the last sample.
// Backpressure: in_ready only in ACCUM; abort drops the window, no result.
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [SUM_W-1:0]  sum,
  output logic              sum_valid,
  output logic              busy,
  output logic              overflow
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;
  logic             busy_q;
  logic             sum_valid_q;
  logic             ovf_q;
  logic [SUM_W-1:0] sum_q;

  logic             accept;
  logic             last_sample;
  logic             core_clr;
  logic             core_en;
  logic [SUM_W-1:0] acc;
  logic             acc_ovf;

  // len=0 loads 0; the count wraps through all-ones, so "count==1" still marks
  // the 2^CNT_W-th sample without a wider counter.
  assign accept      = in_ready_q & in_valid;
  assign last_sample = (cnt_q == CNT_W'(1));
  assign cnt_d       = cnt_q - CNT_W'(1);
  assign core_clr    = (state_q == ST_CLEAR);
  assign core_en     = accept & ~abort;

  accum_core #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (core_clr),
    .en_i   (core_en),
    .data_i (in_data),
    .acc_o  (acc),
    .ovf_o  (acc_ovf)
  );

  // Window FSM with registered handshake/status outputs and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= len;
            busy_q  <= 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (abort) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (accept) begin
            cnt_q <= cnt_d;
            if (last_sample) begin
              in_ready_q <= 1'b0;
              state_q    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          sum_q       <= acc;
          ovf_q       <= acc_ovf;
          sum_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign sum_valid = sum_valid_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Bench for accum_ctrl: directed window scenarios plus random traffic.
// Outputs are compared every cycle against a sum-of-samples reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [11:0] len;
  logic [12:0] in_data;
  logic        in_ready, sum_valid, busy, overflow;
  logic [20:0] sum;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  localparam longint SUM_MAX = (longint'(1) << 21) - 1;

  always #5 clk = ~clk;

  accum_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the window result is min(plain sum of accepted samples, max),
  // overflow is simply "plain sum exceeded max".
  bit     m_busy = 0, m_ready = 0, m_clear = 0, m_done = 0;
  bit     e_sv = 0, e_ovf = 0;
  longint m_total = 0, e_sum = 0;
  int     m_left = 0;

  always @(posedge clk) begin
    e_sv = 1'b0;
    if (rst) begin
      m_busy = 0; m_ready = 0; m_clear = 0; m_done = 0;
      e_sum = 0; e_ovf = 0; m_total = 0; m_left = 0;
    end else if (m_done) begin
      e_sum  = (m_total > SUM_MAX) ? SUM_MAX : m_total;
      e_ovf  = (m_total > SUM_MAX);
      e_sv   = 1'b1;
      m_done = 0;
      m_busy = 0;
    end else if (m_clear) begin
      m_clear = 0;
      m_total = 0;
      if (abort) m_busy = 0;
      else       m_ready = 1;
    end else if (m_ready) begin
      if (abort) begin
        m_ready = 0;
        m_busy  = 0;
      end else if (in_valid) begin
        m_total += longint'(in_data);
        m_left--;
        if (m_left == 0) begin
          m_ready = 0;
          m_done  = 1;
        end
      end
    end else if (start) begin
      m_left  = (len == 0) ? 4096 : int'(len);
      m_busy  = 1;
      m_clear = 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp sum_valid", longint'(sum_valid), longint'(e_sv));
      chk("cmp busy",      longint'(busy),      longint'(m_busy));
      chk("cmp in_ready",  longint'(in_ready),  longint'(m_ready));
      chk("cmp sum",       longint'(sum),       e_sum);
      chk("cmp overflow",  longint'(overflow),  longint'(e_ovf));
    end
  end

  task automatic drive(bit r, bit s, int l, bit a, bit v, int d);
    logic [31:0] lv, dv;
    lv = l;
    dv = d;
    @(negedge clk);
    rst      = r;
    start    = s;
    len      = lv[11:0];
    abort    = a;
    in_valid = v;
    in_data  = dv[12:0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample(int d);
    drive(0, 0, 0, 0, 1, d);
  endtask

  task automatic begin_window(int l);
    drive(0, 1, l, 0, 0, 0);
    idle();
  endtask

  task automatic wait_pulse(string nm, longint es, bit eo);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      idle();
      if (sum_valid) begin
        seen = 1'b1;
        chk({nm, " sum"}, longint'(sum), es);
        chk({nm, " overflow"}, longint'(overflow), longint'(eo));
      end
    end
    chk({nm, " pulse seen"}, longint'(seen), 1);
  endtask

  task automatic count_pulses(int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      idle();
      cnt += int'(sum_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r, s, l, a, v, d;

    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset sum",       longint'(sum), 0);
    chk("reset busy",      longint'(busy), 0);
    chk("reset in_ready",  longint'(in_ready), 0);
    chk("reset sum_valid", longint'(sum_valid), 0);
    chk("reset overflow",  longint'(overflow), 0);

    // Reset wins over a simultaneous start.
    drive(1, 1, 4, 0, 1, 5);
    idle();
    chk("rst over start busy", longint'(busy), 0);

    // Four samples back to back; pulse lands in the 2nd cycle after the accept edge.
    begin_window(4);
    sample(1); sample(2); sample(3); sample(4);
    idle();
    chk("034 no pulse in DONE", longint'(sum_valid), 0);
    chk("034 busy in DONE",     longint'(busy), 1);
    idle();
    chk("034 pulse",    longint'(sum_valid), 1);
    chk("034 sum",      longint'(sum), 10);
    chk("034 overflow", longint'(overflow), 0);
    idle();
    chk("034 single pulse", longint'(sum_valid), 0);
    chk("034 sum held",     longint'(sum), 10);

    // Gaps in in_valid are not counted.
    begin_window(3);
    sample(100); idle(); sample(200); idle(); idle(); sample(300);
    wait_pulse("035", 600, 0);

    // Full-length window saturates; next window starts clean.
    begin_window(0);
    repeat (4096) sample(8191);
    wait_pulse("036 sat", 2097151, 1);
    begin_window(1);
    sample(5);
    wait_pulse("036 after sat", 5, 0);

    // Re-pulsed start ignored, abort after two accepts.
    begin_window(4);
    sample(1); sample(2); sample(3); sample(4);
    wait_pulse("037 setup", 10, 0);
    begin_window(4);
    drive(0, 1, 4, 0, 1, 1);
    sample(2);
    drive(0, 0, 0, 1, 0, 0);
    idle();
    chk("037 busy dropped",     longint'(busy), 0);
    chk("037 in_ready dropped", longint'(in_ready), 0);
    count_pulses(6, n);
    chk("037 no pulse",  longint'(n), 0);
    chk("037 sum kept",  longint'(sum), 10);

    // Reset mid-window.
    begin_window(4);
    sample(3); sample(4);
    drive(1, 0, 0, 0, 1, 9);
    idle();
    chk("038 busy",     longint'(busy), 0);
    chk("038 in_ready", longint'(in_ready), 0);
    chk("038 sum",      longint'(sum), 0);
    begin_window(1);
    sample(7);
    wait_pulse("038 new window", 7, 0);

    // Abort together with the final sample.
    begin_window(2);
    sample(3);
    drive(0, 0, 0, 1, 1, 9);
    idle();
    chk("039 busy", longint'(busy), 0);
    count_pulses(5, n);
    chk("039 no pulse", longint'(n), 0);
    chk("039 sum kept", longint'(sum), 7);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom % 100 == 0) ? 1 : 0;
      s = ($urandom % 4 == 0) ? 1 : 0;
      l = ($urandom % 16 == 0) ? 0 : int'($urandom_range(1, 6));
      a = ($urandom % 25 == 0) ? 1 : 0;
      v = ($urandom % 10 < 7) ? 1 : 0;
      d = ($urandom % 4 == 0) ? 8191 : int'($urandom % 8192);
      drive(r[0], s[0], l, a[0], v[0], d);
    end
    repeat (4) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 Parameter DATA_W, default 13, width of unsigned input sample.
REQ-002 Parameter SUM_W, default 21, width of accumulated sum.
REQ-003 Parameter CNT_W, default 12, width of window-length field.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as below.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin a window; honoured only in IDLE.
REQ-008 len  in  CNT_W  window length N; 0 encodes 2^CNT_W; sampled when start is honoured.
REQ-009 abort  in  1  terminates the window without producing a result.
REQ-010 in_valid  in  1  sample present.
REQ-011 in_ready  out  1  block accepts sample this cycle.
REQ-012 in_data  in  DATA_W  unsigned sample.
REQ-013 sum  out  SUM_W  registered result of the last completed window.
REQ-014 sum_valid  out  1  one-cycle pulse, sum updated.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 overflow  out  1  saturation flag of the last completed window.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, ACCUM and DONE.
REQ-018 IDLE: in_ready=0, busy=0; start=1 latches len into remaining count, next state CLEAR.
REQ-019 CLEAR: lasts exactly 1 cycle; accumulator and internal overflow are zeroed; in_ready=0; next state ACCUM.
REQ-020 ACCUM: in_ready=1; each in_valid&in_ready cycle adds zero-extended in_data and decrements the count; non-valid cycles do not change state or count.
REQ-021 Acceptance of the N-th sample SHALL move ACCUM to DONE.
REQ-022 DONE: lasts 1 cycle; sum<=accumulator, overflow<=internal flag, sum_valid=1; next state IDLE.
REQ-023 Latency: sum_valid SHALL assert exactly 2 cycles after the clock edge that accepts the final sample (1 cycle to enter DONE, 1 to register the result).
REQ-024 Arithmetic: saturate at 2^SUM_W-1; any addition whose true result exceeds this SHALL clamp the accumulator and set the internal overflow flag, which stays set until the next CLEAR.
REQ-025 start outside IDLE SHALL be ignored, including in DONE.
REQ-026 abort in CLEAR or ACCUM SHALL force IDLE next cycle, with no sum_valid and sum/overflow unchanged.
REQ-027 A simultaneous abort and sample acceptance SHALL resolve in favour of abort; the sample is discarded.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 sum and overflow SHALL hold their values between DONE cycles.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, with sum=0, sum_valid=0, overflow=0, busy=0, in_ready=0, and the accumulator and count cleared.
REQ-031 rst SHALL take priority over start, abort and in_valid in every state, including mid-window.

Structure
REQ-032 Package accum_ctrl_pkg SHALL hold the DATA_W/SUM_W/CNT_W defaults and the FSM state enumeration.
REQ-033 Sub-module accum_core SHALL implement the registered saturating adder with clear, enable and overflow; accum_ctrl holds the FSM, counter and result registers.

Verification
REQ-034 len=4, in_valid held high, data 1,2,3,4 -> sum_valid pulses once 2 cycles after the 4th accept, with sum=10, overflow=0.
REQ-035 len=3, in_valid high only on cycles 0, 2 and 5 of ACCUM, data 100,200,300 -> sum=600; cycles where in_valid=0 are not counted.
REQ-036 len=0 (4096 samples), data 8191 every cycle -> sum=2097151, overflow=1; a following window with len=1, data 5 -> sum=5, overflow=0.
REQ-037 A completed window with sum=10, then start on the next window, start re-pulsed during ACCUM, and abort after 2 accepts -> no sum_valid, sum stays 10, busy drops the next cycle.
REQ-038 rst during ACCUM after 2 samples -> next cycle IDLE, sum=0, busy=0, in_ready=0; a new len=1 window with data 7 -> sum=7.
REQ-039 abort and in_valid asserted in the same cycle as the final sample -> no sum_valid, FSM returns to IDLE.
